mul_share_arb: RTL and testbench

- Shares one pipelined 32x32->64 integer multiplier among NUM_REQ requesters inside the FPU. Typical requesters are the mantissa-multiply, divide-iteration and integer-mul paths.
- Round-robin arbitration with valid/ready request handshakes.
- Fixed-latency multiply pipeline, with a tag carried alongside each operation.
- Credit-protected result FIFO, so backpressure on the single response port never drops a product.

---
 rtl/mul_share_pkg.sv | 28 ++
 rtl/mul_share_fifo.sv | 63 ++++++
 rtl/mul_share_arb.sv | 132 +++++++++++++
 tb/tb_mul_share_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types for mul_share_arb: multiplier pipeline entry, result FIFO entry, id sizing.
// Latency: n/a (types only).
// Backpressure: n/a.
package mul_share_pkg;

    localparam int MSA_NUM_REQ = 4;
    localparam int MSA_WIDTH   = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MSA_ID_W = id_w(MSA_NUM_REQ);

    typedef struct packed {
        logic                   valid;
        logic [MSA_WIDTH-1:0]   a;
        logic [MSA_WIDTH-1:0]   b;
        logic [MSA_ID_W-1:0]    id;
        logic                   sgn;
    } pipe_ent_t;

    typedef struct packed {
        logic [2*MSA_WIDTH-1:0] c;
        logic [MSA_ID_W-1:0]    id;
    } fifo_ent_t;

endpackage

// File: rtl/mul_share_fifo.sv
// Circular-buffer FIFO with first-word-fall-through head and occupancy count.
// Latency: a write is visible at the head one cycle later.
// Backpressure: caller must not push while full unless popping in the same cycle.
module mul_share_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_vld,
    input  logic [W-1:0]               i_wr_dat,
    output logic                       o_rd_vld,
    input  logic                       i_rd_rdy,
    output logic [W-1:0]               o_rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full   = (r_count == CW'(DEPTH));
    assign o_rd_vld = (r_count != '0);
    assign w_pop    = o_rd_vld && i_rd_rdy;
    // Head is forced to zero when empty so the response port idles at zero.
    assign o_rd_dat = o_rd_vld ? r_mem[r_rd_ptr] : '0;
    assign o_count  = r_count;

    always_ff @(posedge i_clk) begin
        if (i_wr_vld) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_vld) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_wr_vld, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_wr_vld && w_full && !w_pop));

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin shared WIDTHxWIDTH multiplier; MUL_SHARE_ARB_SIGNED_EN adds per-request signed mode.
// Latency: accept to rsp_valid is LAT+1 cycles minimum; one accept per cycle sustained.
// Backpressure: issue gated by result-FIFO credits, so a stalled rsp port never drops a product.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ    = MSA_NUM_REQ,
    parameter int WIDTH      = MSA_WIDTH,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
`ifdef MUL_SHARE_ARB_SIGNED_EN
    input  logic [NUM_REQ-1:0]         i_req_signed,
`endif
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [2*WIDTH-1:0]         o_rsp_c,
    output logic [$clog2(NUM_REQ)-1:0] o_rsp_id
);
    localparam int ID_W = id_w(NUM_REQ);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    pipe_ent_t        r_pipe [1:LAT];
    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_live;

    logic             w_grant_vld;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_credit_ok;
    logic             w_accept;
    logic             w_pop;
    int               w_inflight;
    logic [CW-1:0]    w_fifo_count;
    pipe_ent_t        w_ent;
    pipe_ent_t        w_tail;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    fifo_ent_t        w_wr_ent;
    fifo_ent_t        w_head;

    always_comb begin : arb
        int j;
        j           = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_grant_vld && i_req_valid[j]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = ID_W'(j);
            end
        end
    end

    always_comb begin
        w_inflight = 0;
        for (int s = 1; s <= LAT; s++) begin
            w_inflight = w_inflight + int'(r_pipe[s].valid);
        end
    end

    // A same-cycle pop frees a slot, so a full FIFO being drained still admits one issue.
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign w_credit_ok = r_live && ((FIFO_DEPTH + int'(w_pop)) > (w_inflight + int'(w_fifo_count)));
    assign w_accept    = w_credit_ok && w_grant_vld;

    always_comb begin
        o_req_ready = '0;
        if (w_accept) o_req_ready[w_grant_idx] = 1'b1;
    end

    always_comb begin
        w_ent       = '0;
        w_ent.valid = w_accept;
        w_ent.a     = i_req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
        w_ent.b     = i_req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
        w_ent.id    = w_grant_idx;
`ifdef MUL_SHARE_ARB_SIGNED_EN
        w_ent.sgn   = i_req_signed[w_grant_idx];
`else
        w_ent.sgn   = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live   <= 1'b0;
            r_rr_ptr <= '0;
            for (int s = 1; s <= LAT; s++) r_pipe[s] <= '0;
        end else begin
            r_live    <= 1'b1;
            r_pipe[1] <= w_ent;
            for (int s = 2; s <= LAT; s++) r_pipe[s] <= r_pipe[s-1];
            if (w_accept) begin
                r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
            end
        end
    end

    // Operands travel the pipe; the multiply sits at the tail and retiming spreads it over the stages.
    // Sign extension to 2*WIDTH makes one truncated product serve signed and unsigned modes.
    assign w_tail      = r_pipe[LAT];
    assign w_a_ext     = {{WIDTH{w_tail.sgn & w_tail.a[WIDTH-1]}}, w_tail.a};
    assign w_b_ext     = {{WIDTH{w_tail.sgn & w_tail.b[WIDTH-1]}}, w_tail.b};
    assign w_wr_ent.c  = w_a_ext * w_b_ext;
    assign w_wr_ent.id = w_tail.id;

    mul_share_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fifo_ent_t))
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wr_vld (w_tail.valid),
        .i_wr_dat (w_wr_ent),
        .o_rd_vld (o_rsp_valid),
        .i_rd_rdy (i_rsp_ready),
        .o_rd_dat (w_head),
        .o_count  (w_fifo_count)
    );

    assign o_rsp_c  = w_head.c;
    assign o_rsp_id = w_head.id;

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: scoreboard of products in acceptance order plus scenario tasks.
`timescale 1ns/1ps
module tb_mul_share_arb;
    localparam int NUM_REQ    = 4;
    localparam int WIDTH      = 32;
    localparam int LAT        = 3;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [63:0] c;
        logic [1:0]  id;
    } exp_t;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
`ifdef MUL_SHARE_ARB_SIGNED_EN
    logic [NUM_REQ-1:0]       req_signed;
`endif
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [63:0]              rsp_c;
    logic [1:0]               rsp_id;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb[$];
    logic        hold_vld = 1'b0;
    logic [63:0] hold_c;
    logic [1:0]  hold_id;

    mul_share_arb #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
`ifdef MUL_SHARE_ARB_SIGNED_EN
        .i_req_signed(req_signed),
`endif
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_c     (rsp_c),
        .o_rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb2;
        if (s) begin
            sa  = $signed(a);
            sb2 = $signed(b);
            return sa * sb2;
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    function automatic logic sgn_of(input int i);
`ifdef MUL_SHARE_ARB_SIGNED_EN
        return req_signed[i];
`else
        return (i < 0);
`endif
    endfunction

    // Scoreboard: push on accept, pop and compare on response, check head stability under stall.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                tests++;
                if (!rsp_valid || rsp_c !== hold_c || rsp_id !== hold_id) begin
                    fails++;
                    $display("FAIL rsp_hold: got v=%0b c=%h id=%0d, need v=1 c=%h id=%0d",
                             rsp_valid, rsp_c, rsp_id, hold_c, hold_id);
                end
            end
            hold_vld = rsp_valid && !rsp_ready;
            hold_c   = rsp_c;
            hold_id  = rsp_id;
            if (req_ready != '0) begin
                tests++;
                if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
                    fails++;
                    $display("FAIL grant_onehot: ready=%b valid=%b", req_ready, req_valid);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.c  = model(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], sgn_of(i));
                    e.id = 2'(i);
                    sb.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_extra: got c=%h id=%0d, need no response", rsp_c, rsp_id);
                end else begin
                    e = sb.pop_front();
                    if (rsp_c !== e.c || rsp_id !== e.id) begin
                        fails++;
                        $display("FAIL rsp_data: got c=%h id=%0d, need c=%h id=%0d", rsp_c, rsp_id, e.c, e.id);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic new_operands(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i]) begin
                req_a[i*WIDTH +: WIDTH] = $urandom();
                req_b[i*WIDTH +: WIDTH] = $urandom();
`ifdef MUL_SHARE_ARB_SIGNED_EN
                req_signed[i] = 1'($urandom_range(0, 1));
`endif
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: got %0d outstanding, need 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_and_wait(input int id, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] c, output logic [1:0] rid, output int lat);
        int t0;
        bit got;
        t0  = 0;
        got = 1'b0;
        lat = -1;
        c   = '0;
        rid = '0;
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid     = '0;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                t0  = cyc;
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        for (int k = 0; k < 20 && got && lat < 0; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc - t0;
                c   = rsp_c;
                rid = rsp_id;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rsp_ready = 1'b1;
        req_valid = '1;
        new_operands('1);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); end
        tests++; if (rsp_c !== 64'h0) begin fails++; $display("FAIL reset_rsp_c: got %h need 0", rsp_c); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d need 0", rsp_id); end
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready: got %b need 0000", req_ready); end
        apply_reset();
    endtask

    task automatic test_single();
        logic [63:0] c;
        logic [1:0]  rid;
        int          lat;
        issue_and_wait(2, 32'hFFFF_FFFF, 32'h2, c, rid, lat);
        tests++; if (lat != LAT + 1) begin fails++; $display("FAIL single_latency: got %0d need %0d", lat, LAT + 1); end
        tests++; if (c !== 64'h1_FFFF_FFFE) begin fails++; $display("FAIL single_c: got %h need 00000001fffffffe", c); end
        tests++; if (rid !== 2'd2) begin fails++; $display("FAIL single_id: got %0d need 2", rid); end
    endtask

    task automatic test_boundaries();
        logic [63:0] c;
        logic [1:0]  rid;
        int          lat;
        issue_and_wait(1, 32'h0, 32'h0, c, rid, lat);
        tests++; if (lat < 0 || c !== 64'h0 || rid !== 2'd1) begin
            fails++; $display("FAIL zero_product: got c=%h id=%0d lat=%0d need c=0 id=1", c, rid, lat);
        end
        issue_and_wait(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, rid, lat);
        tests++; if (lat < 0 || c !== 64'hFFFF_FFFE_0000_0001 || rid !== 2'd3) begin
            fails++; $display("FAIL max_product: got c=%h id=%0d lat=%0d need c=fffffffe00000001 id=3", c, rid, lat);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] mask;
        logic [NUM_REQ-1:0] want;
        int exp_id;
        apply_reset();
        new_operands('1);
        req_valid = '1;
        exp_id    = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            want = 4'b0001 << exp_id;
            tests++;
            if (req_ready !== want) begin
                fails++;
                $display("FAIL rr_grant: cycle %0d got ready=%b need %b", k, req_ready, want);
            end
            mask   = req_ready & req_valid;
            exp_id = (exp_id + 1) % NUM_REQ;
            @(posedge clk);
            #1 new_operands(mask);
        end
        req_valid = '0;
        wait_drain("rr");
    endtask

    task automatic test_backpressure();
        logic [NUM_REQ-1:0] mask;
        int accepts;
        accepts   = 0;
        rsp_ready = 1'b0;
        new_operands('1);
        req_valid = '1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mask    = req_ready & req_valid;
            accepts += $countones(mask);
            @(posedge clk);
            #1 new_operands(mask);
        end
        tests++; if (accepts != FIFO_DEPTH) begin fails++; $display("FAIL bp_accepts: got %0d need %0d", accepts, FIFO_DEPTH); end
        @(negedge clk);
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL bp_stalled: got ready=%b need 0000", req_ready); end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if (!(rsp_valid === 1'b1 && req_ready != '0)) begin
            fails++; $display("FAIL bp_resume: got rsp_valid=%b ready=%b need pop with accept", rsp_valid, req_ready);
        end
        mask = req_ready & req_valid;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 new_operands(mask);
            @(negedge clk);
            mask = req_ready & req_valid;
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_drain("bp");
    endtask

    task automatic test_reset_midflight();
        logic [NUM_REQ-1:0] mask;
        int stale;
        apply_reset();
        rsp_ready = 1'b0;
        new_operands('1);
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mask = req_ready & req_valid;
            @(posedge clk);
            #1 new_operands(mask);
        end
        rst_n = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midrst_rsp_valid: got %b need 0", rsp_valid); end
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL midrst_req_ready: got %b need 0000", req_ready); end
        repeat (2) @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        stale     = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        tests++; if (stale != 0) begin fails++; $display("FAIL midrst_stale: got %0d stale cycles need 0", stale); end
        @(posedge clk);
        #1 req_valid = '1;
        @(negedge clk);
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL midrst_rr_ptr: got ready=%b need 0001", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        wait_drain("midrst");
    endtask

`ifdef MUL_SHARE_ARB_SIGNED_EN
    task automatic test_signed();
        logic [63:0] c;
        logic [1:0]  rid;
        int          lat;
        req_signed[0] = 1'b1;
        issue_and_wait(0, 32'hFFFF_FFFF, 32'h3, c, rid, lat);
        tests++; if (lat < 0 || c !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            fails++; $display("FAIL signed_mul: got c=%h lat=%0d need fffffffffffffffd", c, lat);
        end
        req_signed[0] = 1'b0;
        issue_and_wait(0, 32'hFFFF_FFFF, 32'h3, c, rid, lat);
        tests++; if (lat < 0 || c !== 64'h2_FFFF_FFFD) begin
            fails++; $display("FAIL unsigned_mode: got c=%h lat=%0d need 00000002fffffffd", c, lat);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef MUL_SHARE_ARB_SIGNED_EN
        req_signed = '0;
`endif
        test_reset();
        test_single();
        test_boundaries();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
`ifdef MUL_SHARE_ARB_SIGNED_EN
        apply_reset();
        test_signed();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
